// File: rtl/mm_result_collector.sv
// Receive end of the systolic GF(2^M) multiplier: deserialise po/ctro frames into a result FIFO.
// Optional feature: define MM_COLLECT_PARITY_EN to add res_par (stored parity of the head word).
module mm_result_collector #(
    parameter int M     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   po,
    input  logic                   ctro,
    input  logic                   clr,
    output logic [M:1]             res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   frame_err
`ifdef MM_COLLECT_PARITY_EN
    ,
    output logic                   res_par
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(M);
`ifdef MM_COLLECT_PARITY_EN
    localparam int W  = M + 1;
`else
    localparam int W  = M;
`endif

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state_q, state_d;
    logic [M-1:1]   shift_q;
    logic [CW-1:0]  cnt_q;
    logic           load, adv, word_done, ferr_set;

    logic [W-1:0]   mem [DEPTH];
    logic [AW:0]    wr_cnt, rd_cnt;
    logic [M-1:0]   word;
    logic [W-1:0]   entry, head;
    logic           pop, full, wr_en, ovf_set;

    // Framing FSM: a ctro while a frame is open (including its last bit) aborts that frame.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        adv       = 1'b0;
        word_done = 1'b0;
        ferr_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctro) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ctro) begin
                    load     = 1'b1;
                    ferr_set = 1'b1;
                end else if (cnt_q == CW'(M - 1)) begin
                    word_done = 1'b1;
                    state_d   = IDLE;
                end else begin
                    adv = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (load || adv)
                shift_q <= {shift_q[M-2:1], po};
            if (load)
                cnt_q <= CW'(1);
            else if (adv)
                cnt_q <= cnt_q + CW'(1);
            else if (word_done)
                cnt_q <= '0;
        end
    end

    // The final bit goes straight into the FIFO entry, not through the shift register.
    assign word = {shift_q, po};
`ifdef MM_COLLECT_PARITY_EN
    assign entry = {^word, word};
`else
    assign entry = word;
`endif

    assign level     = wr_cnt - rd_cnt;
    assign res_valid = (level != '0);
    assign full      = (level == (AW+1)'(DEPTH));
    assign pop       = res_valid & res_ready;
    // When full, a simultaneous pop frees the slot the write lands in.
    assign wr_en     = word_done & (~full | pop);
    assign ovf_set   = word_done & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_cnt[AW-1:0]] <= entry;
                wr_cnt              <= wr_cnt + 1'b1;
            end
            if (pop)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

    // Sticky flags: a new error on the clearing edge keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf       <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ovf       <= (ovf & ~clr) | ovf_set;
            frame_err <= (frame_err & ~clr) | ferr_set;
        end
    end

    assign head     = mem[rd_cnt[AW-1:0]];
    assign res_data = head[M-1:0];
`ifdef MM_COLLECT_PARITY_EN
    assign res_par  = head[M];
`endif

endmodule
